// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory handshake, decoder feedback and the
// fetched-instruction outputs. The fetch unit is the master; the memory,
// decoder and pipeline side is the slave.
interface instr_fetch_unit_if;
  // Instruction-memory handshake
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  // Downstream / decoder feedback
  logic        stall;
  logic        branch;
  logic        branch_ne;
  logic        zero;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;

  // Fetch results
  logic [31:0] pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata,
    input  stall,
    input  branch,
    input  branch_ne,
    input  zero,
    input  branch_offset,
    input  jump,
    input  jump_index,
    output pc,
    output if_instr,
    output if_pc4,
    output if_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata,
    output stall,
    output branch,
    output branch_ne,
    output zero,
    output branch_offset,
    output jump,
    output jump_index,
    input  pc,
    input  if_instr,
    input  if_pc4,
    input  if_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS front end: owns the PC, fetches one word at a time over a req/ready
// handshake, holds it for the decoder, then picks the next PC from the
// decoder's jump/branch outputs and the ALU zero flag.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [1:0] StBoot  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        taken;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  // Next-PC selection; only consumed in HOLD with stall low, jump beats branch.
  always_comb begin
    jump_target   = {pc4_q[31:28], bus.jump_index, 2'b00};
    branch_target = pc4_q + (bus.branch_offset << 2);
    taken         = bus.branch & (bus.zero ^ bus.branch_ne);
    if (bus.jump) begin
      next_pc = jump_target;
    end else if (taken) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc4_q;
    end
  end

  // Fetch sequencing: boot idle cycle, wait for ready, hold until consumed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      StBoot: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        // While stalled the decoder feedback is ignored entirely.
        if (!bus.stall) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StBoot;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any in-flight request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Outputs are straight decodes of registered state, so they drop with rst.
  always_comb begin
    bus.imem_req  = (state_q == StFetch);
    bus.imem_addr = pc_q;
    bus.pc        = pc_q;
    bus.if_instr  = instr_q;
    bus.if_pc4    = pc4_q;
    bus.if_valid  = valid_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations
// plus a randomized run, all cross-checked every cycle against a
// transaction-level model of the fetch front end.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   captures = 0;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: an instruction is either being awaited, held, or we are booting.
  bit          m_boot;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot  = 1'b1;
      m_valid = 1'b0;
      m_pc    = RST_PC;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_valid) begin
      if (bus.imem_ready === 1'b1) begin
        m_instr = bus.imem_rdata;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        captures++;
      end
    end else if (bus.stall !== 1'b1) begin
      if (bus.jump) begin
        m_pc = {m_pc4[31:28], bus.jump_index, 2'b00};
      end else if (bus.branch && (bus.zero != bus.branch_ne)) begin
        m_pc = m_pc4 + bus.branch_offset * 32'd4;
      end else begin
        m_pc = m_pc4;
      end
      m_valid = 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    chk("imem_req", {31'h0, bus.imem_req}, {31'h0, (!m_boot && !m_valid)});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("pc", bus.pc, m_pc);
    chk("if_valid", {31'h0, bus.if_valid}, {31'h0, m_valid});
    chk("if_instr", bus.if_instr, m_instr);
    chk("if_pc4", bus.if_pc4, m_pc4);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ctrl();
    bus.branch        = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.zero          = 1'b0;
    bus.branch_offset = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_index    = 26'h0;
    bus.stall         = 1'b0;
  endtask

  // From FETCH: accept one word, leaving the unit in HOLD.
  task automatic capture(input logic [31:0] word);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ready = 1'b0;
  endtask

  // From FETCH: capture a word and branch so the next fetch is at target.
  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] diff;
    capture($urandom);
    diff = target - m_pc4;
    bus.branch        = 1'b1;
    bus.zero          = 1'b1;
    bus.branch_ne     = 1'b0;
    bus.branch_offset = diff >> 2;
    tick();
    clear_ctrl();
    chk("goto_pc", bus.pc, target);
  endtask

  initial begin
    logic [31:0] words [2];
    logic [31:0] addr;
    logic [31:0] r;
    logic [31:0] held;
    words[0] = 32'h2008_0005;
    words[1] = 32'h2009_0003;

    rst = 1'b1;
    clear_ctrl();
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("reset_req", {31'h0, bus.imem_req}, 32'h0);
    chk("reset_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("reset_pc", bus.pc, 32'h0040_0000);
    chk("reset_instr", bus.if_instr, 32'h0);

    // Boot: one idle cycle, then fetch at RESET_PC with ready tied high.
    rst = 1'b0;
    chk("boot_idle_req", {31'h0, bus.imem_req}, 32'h0);
    tick();
    chk("boot_fetch_req", {31'h0, bus.imem_req}, 32'h1);
    chk("boot_fetch_addr", bus.imem_addr, 32'h0040_0000);
    tick();
    chk("boot_valid", {31'h0, bus.if_valid}, 32'h1);
    chk("boot_pc4", bus.if_pc4, 32'h0040_0004);
    bus.imem_ready = 1'b0;

    // Jump to address 0 for the sequential test.
    bus.jump = 1'b1;
    bus.jump_index = 26'h0;
    tick();
    clear_ctrl();
    chk("jump_to_zero", bus.imem_addr, 32'h0);

    // Sequential fetch with 3 wait cycles per word.
    addr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 3; w++) begin
        tick();
        chk("wait_addr_stable", bus.imem_addr, addr);
        chk("wait_req", {31'h0, bus.imem_req}, 32'h1);
      end
      capture(words[i]);
      chk("seq_instr", bus.if_instr, words[i]);
      chk("seq_pc4", bus.if_pc4, addr + 32'd4);
      tick();
      addr = addr + 32'd4;
      chk("seq_next_addr", bus.imem_addr, addr);
    end
    chk("seq_third_addr", bus.imem_addr, 32'h8);

    // beq taken backwards from if_pc4 = 0x100.
    goto_pc(32'h0000_00FC);
    capture(32'h1000_FFFE);
    chk("beq_pc4", bus.if_pc4, 32'h100);
    bus.branch = 1'b1; bus.branch_ne = 1'b0; bus.zero = 1'b1;
    bus.branch_offset = 32'hFFFF_FFFE;
    tick();
    clear_ctrl();
    chk("beq_taken", bus.imem_addr, 32'h0000_00F8);

    // bne with zero=1: not taken.
    goto_pc(32'h0000_00FC);
    capture(32'h1400_FFFE);
    bus.branch = 1'b1; bus.branch_ne = 1'b1; bus.zero = 1'b1;
    bus.branch_offset = 32'hFFFF_FFFE;
    tick();
    clear_ctrl();
    chk("bne_not_taken", bus.imem_addr, 32'h0000_0100);

    // Jump beats a simultaneously taken branch.
    goto_pc(32'h1000_0004);
    capture(32'h0800_0040);
    chk("jmp_pc4", bus.if_pc4, 32'h1000_0008);
    bus.jump = 1'b1; bus.jump_index = 26'h000_0040;
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 32'h5;
    tick();
    clear_ctrl();
    chk("jump_priority", bus.imem_addr, 32'h1000_0100);

    // Stall for 4 cycles while decoder inputs toggle.
    held = $urandom;
    capture(held);
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      bus.branch = r[0]; bus.zero = r[1]; bus.branch_ne = r[2]; bus.jump = r[3];
      bus.jump_index = r[31:6];
      bus.branch_offset = $urandom;
      tick();
      chk("stall_instr", bus.if_instr, held);
      chk("stall_pc", bus.pc, 32'h1000_0100);
      chk("stall_req", {31'h0, bus.imem_req}, 32'h0);
    end
    bus.stall = 1'b0;
    bus.jump = 1'b0;
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_ne = 1'b0;
    bus.branch_offset = 32'h1;
    tick();
    clear_ctrl();
    chk("stall_release_branch", bus.imem_addr, 32'h1000_0108);

    // Sequential wrap past the top of the address space.
    goto_pc(32'hFFFF_FFFC);
    capture(32'h0000_0000);
    chk("wrap_pc4", bus.if_pc4, 32'h0);
    tick();
    chk("wrap_next", bus.imem_addr, 32'h0);

    // Async reset mid-FETCH, then a late ready must not be captured.
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("async_req", {31'h0, bus.imem_req}, 32'h0);
    chk("async_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("async_pc", bus.pc, RST_PC);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    tick();
    rst = 1'b0;
    tick();
    chk("late_ready_ignored", bus.if_instr, 32'h0);
    chk("late_ready_valid", {31'h0, bus.if_valid}, 32'h0);
    bus.imem_ready = 1'b0;

    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      bus.imem_ready = (r[2:0] < 3'd4);
      bus.imem_rdata = $urandom;
      bus.stall      = (r[5:3] < 3'd2);
      bus.branch     = r[6];
      bus.branch_ne  = r[7];
      bus.zero       = r[8];
      bus.jump       = (r[11:9] == 3'd0);
      bus.jump_index = r[31:6];
      r = $urandom;
      bus.branch_offset = {{16{r[15]}}, r[15:0]};
      tick();
    end
    checks++;
    if (captures < 200) begin
      errors++;
      $display("FAIL random_progress: got %0d captures expected at least 200", captures);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
